// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and FSM state type for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0]  NOP_INSTR = 32'h0000_0013;  // ADDI x0,x0,0
  localparam int unsigned  PC_INCR   = 4;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD,
    DISCARD
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: owns fetch_pc; applies reset, redirect (word-aligned) and +4 advance.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned              address_width = 12,
  parameter logic [address_width-1:0] reset_pc      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [address_width-1:0] redirect_pc,
  input  logic                     advance,
  output logic [address_width-1:0] fetch_pc,
  output logic [address_width-1:0] fetch_pc_plus_4
);

  localparam logic [address_width-1:0] ALIGN_MASK = ~address_width'(3);

  assign fetch_pc_plus_4 = fetch_pc + address_width'(PC_INCR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= reset_pc;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ALIGN_MASK;
    end else if (advance) begin
      fetch_pc <= fetch_pc_plus_4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding imem request FSM, stall hold register and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the saturating perf_fetch_count / perf_stall_count outputs.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned              data_width    = 32,
  parameter int unsigned              address_width = 12,
  parameter logic [address_width-1:0] reset_pc      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     redirect,
  input  logic [address_width-1:0] redirect_pc,
  output logic                     imem_req,
  output logic [address_width-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [data_width-1:0]    imem_rdata,
  output logic [data_width-1:0]    instruction,
  output logic [address_width-1:0] pc_plus_4,
  output logic [address_width-1:0] pc_current,
  output logic                     instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetch_count,
  output logic [31:0]              perf_stall_count
`endif
);

  localparam logic [data_width-1:0] BUBBLE = data_width'(NOP_INSTR);

  fetch_state_e             state, state_next;
  logic [address_width-1:0] fetch_pc, fetch_pc_plus_4;
  logic [data_width-1:0]    hold_data, fetch_data;
  logic                     consume, capture, in_flight;

  fetch_pc_gen #(
    .address_width(address_width),
    .reset_pc     (reset_pc)
  ) u_pc_gen (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .advance        (consume),
    .fetch_pc       (fetch_pc),
    .fetch_pc_plus_4(fetch_pc_plus_4)
  );

  assign imem_req   = reset && (state == ISSUE);
  assign imem_addr  = fetch_pc;
  assign fetch_data = (state == HOLD) ? hold_data : imem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ISSUE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    consume    = 1'b0;
    capture    = 1'b0;
    // A request is still owed a response after this cycle only if it was not
    // answered now; otherwise DISCARD would wait for a beat that never comes.
    in_flight  = ((state == WAIT || state == DISCARD) && !imem_rvalid) ||
                 (state == ISSUE && imem_ready);
    if (redirect) begin
      state_next = in_flight ? DISCARD : ISSUE;
    end else begin
      unique case (state)
        ISSUE:   if (imem_ready) state_next = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (stall) begin
              capture    = 1'b1;
              state_next = HOLD;
            end else begin
              consume    = 1'b1;
              state_next = ISSUE;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            consume    = 1'b1;
            state_next = ISSUE;
          end
        end
        DISCARD: if (imem_rvalid) state_next = ISSUE;
        default: state_next = ISSUE;
      endcase
    end
  end

  // Leaving HOLD (by consume or redirect) is what invalidates the held word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       hold_data <= '0;
    else if (capture) hold_data <= imem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction <= BUBBLE;
      instr_valid <= 1'b0;
      pc_current  <= '0;
      pc_plus_4   <= '0;
    end else if (flush || redirect) begin
      instruction <= BUBBLE;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (consume) begin
        instruction <= fetch_data;
        instr_valid <= 1'b1;
        pc_current  <= fetch_pc;
        pc_plus_4   <= fetch_pc_plus_4;
      end else begin
        instruction <= BUBBLE;
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_count <= '0;
      perf_stall_count <= '0;
    end else begin
      if (consume && !flush && perf_fetch_count != '1)
        perf_fetch_count <= perf_fetch_count + 32'd1;
      if (stall && perf_stall_count != '1)
        perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, hand sequences and a randomized program-order model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, redirect, ready, rvalid;
  logic [11:0] redirect_pc;
  logic [31:0] rdata;
  logic        req, valid;
  logic [11:0] addr, pc, pc4;
  logic [31:0] instr;

  logic        ready2, rvalid2, req2, valid2;
  logic [31:0] rdata2, instr2;
  logic [11:0] addr2, pc_2, pc4_2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf1, ps1, pf2, ps2;
`endif

  int checks = 0;
  int failures = 0;

  fetch_stage #(.data_width(32), .address_width(12), .reset_pc(12'h000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(req), .imem_addr(addr), .imem_ready(ready),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .instruction(instr), .pc_plus_4(pc4),
    .pc_current(pc), .instr_valid(valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_count(pf1), .perf_stall_count(ps1)
`endif
  );

  fetch_stage #(.data_width(32), .address_width(12), .reset_pc(12'hFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0), .redirect(1'b0),
    .redirect_pc(12'h000), .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2), .instruction(instr2), .pc_plus_4(pc4_2),
    .pc_current(pc_2), .instr_valid(valid2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_count(pf2), .perf_stall_count(ps2)
`endif
  );

  typedef struct {
    logic [4:0]  ctl;      // {stall, flush, redirect, ready, rvalid}
    logic [11:0] rpc;
    logic [31:0] rdata;
    logic        e_req;
    logic [11:0] e_addr;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [11:0] e_pc;
    logic [11:0] e_pc4;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {8'h5A, a, ~a};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pend, had_pend, s, f, r, rv;
    logic [11:0] pend_addr, rpc, exp_next, e4;
    logic [31:0] rd;
    int unsigned lat;
    int          loads, model_stall;
    logic [31:0] prev_instr;
    logic        prev_valid;
    logic [11:0] prev_pc, prev_pc4;

    vecs[0]  = '{5'b00010, 12'h000, 32'h0,        1'b1, 12'h000, NOP,          1'b0, 12'h000, 12'h000};
    vecs[1]  = '{5'b00001, 12'h000, 32'h00500093, 1'b0, 12'h000, 32'h00500093, 1'b1, 12'h000, 12'h004};
    vecs[2]  = '{5'b10010, 12'h000, 32'h0,        1'b1, 12'h004, 32'h00500093, 1'b1, 12'h000, 12'h004};
    vecs[3]  = '{5'b10001, 12'h000, 32'h00A00113, 1'b0, 12'h004, 32'h00500093, 1'b1, 12'h000, 12'h004};
    vecs[4]  = '{5'b10000, 12'h000, 32'h0,        1'b0, 12'h004, 32'h00500093, 1'b1, 12'h000, 12'h004};
    vecs[5]  = '{5'b00001, 12'h000, 32'hDEADBEEF, 1'b0, 12'h004, 32'h00A00113, 1'b1, 12'h004, 12'h008};
    vecs[6]  = '{5'b00000, 12'h000, 32'h0,        1'b1, 12'h008, NOP,          1'b0, 12'h004, 12'h008};
    vecs[7]  = '{5'b00010, 12'h000, 32'h0,        1'b1, 12'h008, NOP,          1'b0, 12'h004, 12'h008};
    vecs[8]  = '{5'b00000, 12'h000, 32'h0,        1'b0, 12'h008, NOP,          1'b0, 12'h004, 12'h008};
    vecs[9]  = '{5'b00100, 12'h103, 32'h0,        1'b0, 12'h008, NOP,          1'b0, 12'h004, 12'h008};
    vecs[10] = '{5'b00001, 12'h000, 32'hBAD00BAD, 1'b0, 12'h100, NOP,          1'b0, 12'h004, 12'h008};
    vecs[11] = '{5'b00010, 12'h000, 32'h0,        1'b1, 12'h100, NOP,          1'b0, 12'h004, 12'h008};
    vecs[12] = '{5'b00001, 12'h000, 32'h00100193, 1'b0, 12'h100, 32'h00100193, 1'b1, 12'h100, 12'h104};
    vecs[13] = '{5'b11000, 12'h000, 32'h0,        1'b1, 12'h104, NOP,          1'b0, 12'h100, 12'h104};
    vecs[14] = '{5'b00100, 12'h200, 32'h0,        1'b1, 12'h104, NOP,          1'b0, 12'h100, 12'h104};
    vecs[15] = '{5'b00010, 12'h000, 32'h0,        1'b1, 12'h200, NOP,          1'b0, 12'h100, 12'h104};
    vecs[16] = '{5'b01001, 12'h000, 32'h11111111, 1'b0, 12'h200, NOP,          1'b0, 12'h100, 12'h104};
    vecs[17] = '{5'b00000, 12'h000, 32'h0,        1'b1, 12'h204, NOP,          1'b0, 12'h100, 12'h104};
    vecs[18] = '{5'b00110, 12'h300, 32'h0,        1'b1, 12'h204, NOP,          1'b0, 12'h100, 12'h104};
    vecs[19] = '{5'b00000, 12'h000, 32'h0,        1'b0, 12'h300, NOP,          1'b0, 12'h100, 12'h104};
    vecs[20] = '{5'b00001, 12'h000, 32'h22222222, 1'b0, 12'h300, NOP,          1'b0, 12'h100, 12'h104};
    vecs[21] = '{5'b00010, 12'h000, 32'h0,        1'b1, 12'h300, NOP,          1'b0, 12'h100, 12'h104};
    vecs[22] = '{5'b00001, 12'h000, 32'h00300213, 1'b0, 12'h300, 32'h00300213, 1'b1, 12'h300, 12'h304};

    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ready = 1'b0; rvalid = 1'b0; rdata = '0;
    ready2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk); #1;
    chk("rst_req", 32'(req), 32'(1'b0));
    chk("rst_req2", 32'(req2), 32'(1'b0));
    chk("rst_instr", instr, NOP);
    chk("rst_valid", 32'(valid), 32'(1'b0));
    chk("rst_pc", 32'(pc), 32'(12'h000));
    chk("rst_pc4", 32'(pc4), 32'(12'h000));
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", pf1, 32'd0);
    chk("rst_perf_stall", ps1, 32'd0);
`endif

    // Wrap instance: reset_pc = 0xFFC
    @(negedge clk);
    reset = 1'b1; ready2 = 1'b1;
    #1;
    chk("first_req", 32'(req), 32'(1'b1));
    chk("first_addr", 32'(addr), 32'(12'h000));
    chk("wrap_req", 32'(req2), 32'(1'b1));
    chk("wrap_addr", 32'(addr2), 32'(12'hFFC));
    @(negedge clk);
    ready2 = 1'b0; rvalid2 = 1'b1; rdata2 = 32'h00700293;
    #1;
    chk("wrap_wait_req", 32'(req2), 32'(1'b0));
    @(posedge clk); #1;
    chk("wrap_instr", instr2, 32'h00700293);
    chk("wrap_valid", 32'(valid2), 32'(1'b1));
    chk("wrap_pc", 32'(pc_2), 32'(12'hFFC));
    chk("wrap_pc4", 32'(pc4_2), 32'(12'h000));
    @(negedge clk);
    rvalid2 = 1'b0;
    #1;
    chk("wrap_next_req", 32'(req2), 32'(1'b1));
    chk("wrap_next_addr", 32'(addr2), 32'(12'h000));

    // Directed vector table
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      {stall, flush, redirect, ready, rvalid} = vecs[i].ctl;
      redirect_pc = vecs[i].rpc;
      rdata = vecs[i].rdata;
      #1;
      chk($sformatf("row%0d_req", i), 32'(req), 32'(vecs[i].e_req));
      chk($sformatf("row%0d_addr", i), 32'(addr), 32'(vecs[i].e_addr));
      @(posedge clk); #1;
      chk($sformatf("row%0d_instr", i), instr, vecs[i].e_instr);
      chk($sformatf("row%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
      chk($sformatf("row%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
      chk($sformatf("row%0d_pc4", i), 32'(pc4), 32'(vecs[i].e_pc4));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("table_perf_fetch", pf1, 32'd4);
    chk("table_perf_stall", ps1, 32'd4);
`endif

    // Reset while WAIT, late response after release
    @(negedge clk);
    {stall, flush, redirect, ready, rvalid} = 5'b00010;
    @(negedge clk);
    ready = 1'b0; reset = 1'b0;
    #1;
    chk("midrst_req", 32'(req), 32'(1'b0));
    chk("midrst_instr", instr, NOP);
    chk("midrst_valid", 32'(valid), 32'(1'b0));
    chk("midrst_pc", 32'(pc), 32'(12'h000));
    @(negedge clk);
    reset = 1'b1; rvalid = 1'b1; rdata = 32'h33333333;
    #1;
    chk("late_req", 32'(req), 32'(1'b1));
    chk("late_addr", 32'(addr), 32'(12'h000));
    @(posedge clk); #1;
    chk("late_valid", 32'(valid), 32'(1'b0));
    chk("late_instr", instr, NOP);
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    chk("late_next_req", 32'(req), 32'(1'b1));
    chk("late_next_addr", 32'(addr), 32'(12'h000));
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_perf_fetch", pf1, 32'd0);
    chk("midrst_perf_stall", ps1, 32'd0);
`endif

    // Randomized run against a program-order model
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    pend = 1'b0; pend_addr = '0; lat = 0; exp_next = 12'h000;
    loads = 0; model_stall = 0;
    prev_instr = NOP; prev_valid = 1'b0; prev_pc = '0; prev_pc4 = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      s   = ($urandom % 4) == 0;
      f   = s && (($urandom % 4) == 0);
      r   = ($urandom % 24) == 0;
      rpc = 12'($urandom);
      rv  = 1'b0;
      rd  = $urandom;
      had_pend = pend;
      if (pend) begin
        if (lat == 0) begin
          rv = 1'b1;
          rd = mem_word(pend_addr);
          pend = 1'b0;
        end else begin
          lat--;
        end
      end
      stall = s; flush = f; redirect = r; redirect_pc = rpc;
      ready = ($urandom % 3) != 0; rvalid = rv; rdata = rd;
      #1;
      if (req && ready) begin
        chk("rnd_single_outstanding", 32'(had_pend), 32'(1'b0));
        chk("rnd_addr_aligned", 32'(addr[1:0]), 32'(2'b00));
        pend = 1'b1;
        pend_addr = addr;
        lat = $urandom_range(0, 2);
      end
      @(posedge clk); #1;
      if (s) model_stall++;
      if (r || f) begin
        chk("rnd_kill_instr", instr, NOP);
        chk("rnd_kill_valid", 32'(valid), 32'(1'b0));
        chk("rnd_kill_pc", 32'(pc), 32'(prev_pc));
        chk("rnd_kill_pc4", 32'(pc4), 32'(prev_pc4));
      end else if (s) begin
        chk("rnd_stall_instr", instr, prev_instr);
        chk("rnd_stall_valid", 32'(valid), 32'(prev_valid));
        chk("rnd_stall_pc", 32'(pc), 32'(prev_pc));
        chk("rnd_stall_pc4", 32'(pc4), 32'(prev_pc4));
      end else if (!valid) begin
        chk("rnd_bubble_instr", instr, NOP);
        chk("rnd_bubble_pc", 32'(pc), 32'(prev_pc));
        chk("rnd_bubble_pc4", 32'(pc4), 32'(prev_pc4));
      end else begin
        e4 = exp_next + 12'd4;
        chk("rnd_load_pc", 32'(pc), 32'(exp_next));
        chk("rnd_load_pc4", 32'(pc4), 32'(e4));
        chk("rnd_load_instr", instr, mem_word(exp_next));
        loads++;
        exp_next = e4;
      end
      if (r) exp_next = rpc & 12'hFFC;
      prev_instr = instr; prev_valid = valid; prev_pc = pc; prev_pc4 = pc4;
    end
    chk("rnd_progress", 32'(loads >= 100), 32'(1'b1));
`ifdef FETCH_PERF_CNT_EN
    chk("rnd_perf_fetch", pf1, 32'(loads));
    chk("rnd_perf_stall", ps1, 32'(model_stall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction fetch stage of the 5-stage pipeline.
- Owns the PC and runs the request/response handshake to instruction memory.
- Drives the IF/ID pipeline register that the decode stage consumes (`instruction`, `pc_plus_4`, `pc_current`).
- Honors the hazard unit's `stall`/`flush` and the taken-branch redirect from the memory stage.

## Interface
- `data_width`, 32, instruction width
- `address_width`, 12, PC / instruction-memory byte-address width
- `reset_pc`, 0, first fetch address after reset
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard unit: hold IF/ID and PC
- `flush`  in  1  hazard unit: load bubble into IF/ID
- `redirect`  in  1  taken branch/jump; restart fetch at `redirect_pc`
- `redirect_pc`  in  address_width  redirect target; bits [1:0] forced to 0
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  address_width  fetch byte address
- `imem_ready`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  data_width  fetched instruction
- `instruction`  out  data_width  IF/ID instruction
- `pc_plus_4`  out  address_width  IF/ID `pc_current + 4`
- `pc_current`  out  address_width  IF/ID PC of `instruction`
- `instr_valid`  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- **Outstanding requests:** at most one in flight. `fetch_pc` holds the address being fetched.
- **FSM states:**
  - ISSUE: `imem_req=1`, `imem_addr=fetch_pc`. `imem_ready=1` → WAIT.
  - WAIT: waiting for `imem_rvalid`.
    - `rvalid` && !`stall` → load IF/ID, `fetch_pc += 4`, → ISSUE.
    - `rvalid` && `stall` → capture into hold register → HOLD.
  - HOLD: on first cycle with !`stall`, load IF/ID from hold register, `fetch_pc += 4`, → ISSUE.
  - DISCARD: drop the next `imem_rvalid` beat, then → ISSUE.
- **Redirect** (highest priority, any state):
  - `fetch_pc <= redirect_pc & ~3`.
  - Hold register is invalidated.
  - Next state: DISCARD if a request is in flight (WAIT, or ISSUE with `imem_ready=1` that cycle), else ISSUE.
  - A response arriving in that same cycle is dropped.
- **IF/ID register**, priority order:
  1. `flush` or `redirect`: bubble.
  2. `stall`: hold all fields.
  3. Otherwise:
     - Load `{imem_rdata` or hold reg, `fetch_pc`, `fetch_pc+4`, `instr_valid=1}` when an instruction is consumed.
     - Load a bubble when none is available.
- **Bubble:** `instruction=32'h0000_0013` (ADDI x0,x0,0), `instr_valid=0`, PC fields unchanged.
- **Protocol errors:** `imem_rvalid` in ISSUE or HOLD is ignored.
- **Arithmetic:** `+4` is modulo 2^address_width. PC `2^address_width-4` wraps to 0, so `pc_plus_4=0`.
- **Reset values:**
  - `instruction=32'h0000_0013`, `instr_valid=0`, `pc_current=0`, `pc_plus_4=0`.
  - `fetch_pc=reset_pc`, state=ISSUE.
  - `imem_req` is 0 while `reset` is low.
- **Reset mid-operation:** in-flight request abandoned; a late response after release is ignored (state ISSUE).

## Timing
- `imem_req`/`imem_addr` are combinational from state and `fetch_pc`.
- First `imem_req` is the first cycle after `reset` deasserts.
- Request accepted in cycle N, `rvalid` at N+k (k≥1) → IF/ID valid at N+k+1.
- Peak throughput: one instruction per 2 cycles (zero-wait memory).
- `redirect` in cycle N → `imem_addr=redirect_pc` at N+1 when no request is in flight.

## Configuration
- `FETCH_PERF_CNT_EN`
  - **Defined:** adds outputs `perf_fetch_count` (32, count of IF/ID loads with `instr_valid=1`) and `perf_stall_count` (32, cycles with `stall=1`).
    - Both saturate at all-ones.
    - Both reset to 0.
  - **Undefined:** ports and counters are absent; behavior is otherwise identical.

## Structure
- **Package `fetch_pkg`:** NOP constant `32'h0000_0013`, PC increment constant (4), FSM state enum {ISSUE, WAIT, HOLD, DISCARD}.
- **Sub-module `fetch_pc_gen`:** holds `fetch_pc`, applies redirect/reset/increment, and produces `fetch_pc+4`.
- **Top level:** FSM, hold register, IF/ID register.

## Test plan
- Reset release, zero-wait memory returning `32'h00500093` at 0x000 → `imem_addr` 0x000, then IF/ID `instruction=32'h00500093`, `pc_current=0x000`, `pc_plus_4=0x004`, `instr_valid=1`. Next `imem_addr=0x004`.
- `stall` high 3 cycles while response arrives → IF/ID holds old values, `imem_req=0`. Buffered instruction appears the cycle after `stall` drops; no duplicate, no loss.
- `redirect` with `redirect_pc=0x103` while in WAIT → stale response dropped, next `imem_addr=0x100`, IF/ID is a bubble (`instr_valid=0`).
- `flush` with `stall` in the same cycle → IF/ID becomes bubble `32'h0000_0013`, `instr_valid=0`.
- `reset_pc=0xFFC` → first instruction has `pc_current=0xFFC`, `pc_plus_4=0x000`, and next `imem_addr=0x000`.
- Reset asserted during WAIT, late `imem_rvalid` after release → ignored, `imem_addr=reset_pc`. With `FETCH_PERF_CNT_EN`, counters read 0.
